// File: rtl/fp_issue_pkg.sv
// -----------------------------------------------------------------------------
// fp_issue_pkg
// Shared types for the floating-point operand issuer.
//   fp32_t        raw IEEE-754 single-precision bit pattern
//   fp_pair_t     one stored operand pair plus its "stored swapped" marker
//   FP_MAG_MSB    top bit of the magnitude field (exponent + mantissa)
//   issue_state_e state of the pair at the head of the queue
//   order_pair()  places the larger-magnitude operand in slot a
// Configuration macro: FP_ISSUE_ORDER_EN (order_pair is used only when defined).
// -----------------------------------------------------------------------------
package fp_issue_pkg;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        fp32_t a;
        fp32_t b;
        logic  swapped;
    } fp_pair_t;

    localparam int FP_MAG_MSB = 30;

    typedef enum logic [1:0] {
        EMPTY,
        PRESENT,
        WAIT_A,
        WAIT_B
    } issue_state_e;

    // Sign bit is ignored, so -3.0 outranks +1.0. Equal magnitudes keep the
    // original order.
    function automatic fp_pair_t order_pair(input fp32_t a, input fp32_t b);
        fp_pair_t p;
        if (b[FP_MAG_MSB:0] > a[FP_MAG_MSB:0]) begin
            p.a       = b;
            p.b       = a;
            p.swapped = 1'b1;
        end else begin
            p.a       = a;
            p.b       = b;
            p.swapped = 1'b0;
        end
        return p;
    endfunction

endpackage

// File: rtl/fp_pair_fifo.sv
// -----------------------------------------------------------------------------
// fp_pair_fifo
// Circular buffer holding operand-pair entries for the issuer.
// The head entry is read combinationally, so a pair written at one edge is
// visible on rdata_o right after that edge.
// Ports:
//   clk, rst   clock; synchronous active-low reset of pointers and level
//   push_i     write wdata_i at the write pointer (caller guarantees !full_o)
//   wdata_i    entry to store
//   pop_i      drop the head entry (caller guarantees !empty_o)
//   rdata_o    head entry
//   level_o    number of stored entries
//   full_o     level_o == DEPTH
//   empty_o    level_o == 0
// Configuration macro: none (FP_ISSUE_ORDER_EN only changes WIDTH).
// -----------------------------------------------------------------------------
module fp_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    // Storage carries no reset; stale entries are never presented because
    // the level gates everything downstream.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/fp_operand_issuer.sv
// -----------------------------------------------------------------------------
// fp_operand_issuer
// Buffers fp32 operand pairs from one pair-wide valid/ready port and issues
// each pair on the adder's independent a/b handshakes. A pair leaves the
// queue only once both halves have been accepted, so a and b never drift
// apart regardless of ready skew.
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   in_a, in_b, in_valid     incoming pair; in_ready = room for one more pair
//   out_a, out_a_valid/ready head operand A to the adder
//   out_b, out_b_valid/ready head operand B to the adder
//   level                    pairs currently stored
//   issued_cnt               pairs fully retired since reset (wraps)
//   out_swapped              (FP_ISSUE_ORDER_EN only) head pair was stored swapped
// Configuration macro: FP_ISSUE_ORDER_EN -- store each pair with the larger
//   magnitude in slot a and flag swapped pairs on out_swapped.
// -----------------------------------------------------------------------------
module fp_operand_issuer
    import fp_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_a,
    output logic                     out_a_valid,
    input  logic                     out_a_ready,
    output logic [WIDTH-1:0]         out_b,
    output logic                     out_b_valid,
    input  logic                     out_b_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              issued_cnt
`ifdef FP_ISSUE_ORDER_EN
    ,
    output logic                     out_swapped
`endif
);

`ifdef FP_ISSUE_ORDER_EN
    localparam int ENTRY_W = $bits(fp_pair_t);
`else
    localparam int ENTRY_W = 2 * WIDTH;
`endif

    logic [ENTRY_W-1:0] wr_entry, rd_entry;
    logic               full, empty;
    logic               push, retire;
    logic               a_hs, b_hs;

    // The register holds only the done flags (PRESENT = neither half taken);
    // EMPTY is derived from the queue level, never stored.
    issue_state_e       state_q, state_d, cur_state;
    logic [15:0]        issued_cnt_q, issued_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= PRESENT;
            issued_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    always_comb begin
        cur_state    = (!rst || empty) ? EMPTY : state_q;
        out_a_valid  = 1'b0;
        out_b_valid  = 1'b0;
        state_d      = state_q;
        issued_cnt_d = issued_cnt_q;

        case (cur_state)
            PRESENT: begin
                out_a_valid = 1'b1;
                out_b_valid = 1'b1;
            end
            WAIT_A:  out_a_valid = 1'b1;
            WAIT_B:  out_b_valid = 1'b1;
            default: ;
        endcase

        a_hs   = out_a_valid && out_a_ready;
        b_hs   = out_b_valid && out_b_ready;
        // A half already taken counts as done; EMPTY has no half to complete.
        retire = (cur_state != EMPTY)
              && (a_hs || cur_state == WAIT_B)
              && (b_hs || cur_state == WAIT_A);

        in_ready = rst && !full;
        push     = in_valid && in_ready;

        if (retire) begin
            state_d      = PRESENT;
            issued_cnt_d = issued_cnt_q + 16'd1;
        end else if (a_hs) begin
            state_d = WAIT_B;
        end else if (b_hs) begin
            state_d = WAIT_A;
        end
    end

`ifdef FP_ISSUE_ORDER_EN
    fp_pair_t wr_pair, rd_pair;

    always_comb begin
        wr_pair = order_pair(in_a, in_b);
    end

    assign wr_entry    = wr_pair;
    assign rd_pair     = fp_pair_t'(rd_entry);
    assign out_a       = rd_pair.a;
    assign out_b       = rd_pair.b;
    assign out_swapped = (cur_state != EMPTY) && rd_pair.swapped;
`else
    assign wr_entry = {in_a, in_b};
    assign out_a    = rd_entry[ENTRY_W-1 -: WIDTH];
    assign out_b    = rd_entry[WIDTH-1:0];
`endif

    fp_pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (retire),
        .rdata_o (rd_entry),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign issued_cnt = issued_cnt_q;

endmodule
